// File: rtl/fp_add_unpack_align.sv
// Front end of the single-precision add/sub pipeline.
// Unpacks both operands, classifies NaN/Inf/zero/subnormal, and aligns the
// smaller-exponent fraction to the larger exponent by an iterative right
// shift that folds shifted-out bits into a sticky LSB. One operation is in
// flight at a time; results are held until the normalize/round/pack stage
// takes them.
module fp_add_unpack_align #(
  parameter int SHIFT_PER_CYCLE = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] floating_point1,
  input  logic [31:0] floating_point2,
  input  logic        is_sub,
  input  logic [2:0]  frm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exponent_max_out,
  output logic        sign1_out,
  output logic        sign2_out,
  output logic [25:0] frac1_out,
  output logic [25:0] frac2_out,
  output logic [2:0]  frm_out,
  output logic        special_valid,
  output logic [31:0] special_result,
  output logic        inv_out
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ALIGN = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  localparam logic [31:0] QNAN      = 32'h7FC0_0000;
  localparam logic [4:0]  MAX_SHIFT = 5'd26;
  localparam logic [4:0]  STEP_MAX  = 5'(SHIFT_PER_CYCLE);

  // One-bit right shift of a {hidden,mant,guard,sticky} fraction; the
  // sticky LSB absorbs whatever falls off so it never clears once set.
  function automatic logic [25:0] shr_sticky1(input logic [25:0] f);
    return {1'b0, f[25:2], f[1] | f[0]};
  endfunction

  // Effective exponent: subnormals and zero behave as exponent 1.
  function automatic logic [7:0] eff_exp(input logic [7:0] e);
    return (e == 8'd0) ? 8'd1 : e;
  endfunction

  logic [1:0]  state_q, state_d;
  logic [4:0]  rem_q, rem_d;
  logic        shift_b_q, shift_b_d;
  logic [7:0]  exp_max_q, exp_max_d;
  logic        sign1_q, sign1_d;
  logic        sign2_q, sign2_d;
  logic [25:0] frac1_q, frac1_d;
  logic [25:0] frac2_q, frac2_d;
  logic [2:0]  frm_q, frm_d;
  logic        spec_q, spec_d;
  logic [31:0] spec_res_q, spec_res_d;
  logic        inv_q, inv_d;

  // Unpacked view of the presented operands.
  logic              a_sign, b_sign_eff;
  logic [7:0]        a_exp, b_exp, a_eff, b_eff;
  logic [22:0]       a_man, b_man;
  logic [25:0]       a_frac0, b_frac0;
  logic signed [9:0] exp_diff;
  logic [9:0]        abs_diff;
  logic [4:0]        d_cap;
  logic [7:0]        exp_max_in;
  logic              b_smaller;

  // Special-case classification of the presented operands.
  logic        a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
  logic        in_spec, in_inv;
  logic [31:0] in_res;

  // Alignment datapath for the current ALIGN cycle.
  logic [25:0] shift_src, shift_res;
  logic [4:0]  step_k;

  // Field extraction, effective exponents and capped exponent distance.
  always_comb begin
    a_sign     = floating_point1[31];
    b_sign_eff = floating_point2[31] ^ is_sub;
    a_exp      = floating_point1[30:23];
    b_exp      = floating_point2[30:23];
    a_man      = floating_point1[22:0];
    b_man      = floating_point2[22:0];
    a_eff      = eff_exp(a_exp);
    b_eff      = eff_exp(b_exp);
    a_frac0    = {(a_exp != 8'd0), a_man, 2'b00};
    b_frac0    = {(b_exp != 8'd0), b_man, 2'b00};
    exp_diff   = $signed({2'b00, a_eff}) - $signed({2'b00, b_eff});
    abs_diff   = exp_diff[9] ? 10'(-exp_diff) : 10'(exp_diff);
    d_cap      = (abs_diff > 10'd26) ? MAX_SHIFT : abs_diff[4:0];
    b_smaller  = (exp_diff > 10'sd0);
    exp_max_in = exp_diff[9] ? b_eff : a_eff;
  end

  // NaN/Inf decision; any NaN wins, then the Inf-Inf conflict, then a lone Inf.
  always_comb begin
    a_nan   = (a_exp == 8'hFF) && (a_man != 23'd0);
    b_nan   = (b_exp == 8'hFF) && (b_man != 23'd0);
    a_snan  = a_nan && !a_man[22];
    b_snan  = b_nan && !b_man[22];
    a_inf   = (a_exp == 8'hFF) && (a_man == 23'd0);
    b_inf   = (b_exp == 8'hFF) && (b_man == 23'd0);
    in_spec = 1'b0;
    in_inv  = 1'b0;
    in_res  = 32'd0;
    if (a_nan || b_nan) begin
      in_spec = 1'b1;
      in_inv  = a_snan || b_snan;
      in_res  = QNAN;
    end else if (a_inf && b_inf && (a_sign != b_sign_eff)) begin
      in_spec = 1'b1;
      in_inv  = 1'b1;
      in_res  = QNAN;
    end else if (a_inf) begin
      in_spec = 1'b1;
      in_res  = {a_sign, 8'hFF, 23'd0};
    end else if (b_inf) begin
      in_spec = 1'b1;
      in_res  = {b_sign_eff, 8'hFF, 23'd0};
    end
  end

  // Up to SHIFT_PER_CYCLE sticky shifts of the smaller operand, stopping at rem.
  always_comb begin
    shift_src = shift_b_q ? frac2_q : frac1_q;
    shift_res = shift_src;
    for (int i = 0; i < SHIFT_PER_CYCLE; i++) begin
      if (5'(i) < rem_q) begin
        shift_res = shr_sticky1(shift_res);
      end
    end
    step_k = (rem_q > STEP_MAX) ? STEP_MAX : rem_q;
  end

  // Control FSM and capture/update of the operand registers.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    shift_b_d  = shift_b_q;
    exp_max_d  = exp_max_q;
    sign1_d    = sign1_q;
    sign2_d    = sign2_q;
    frac1_d    = frac1_q;
    frac2_d    = frac2_q;
    frm_d      = frm_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    inv_d      = inv_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          exp_max_d  = exp_max_in;
          sign1_d    = a_sign;
          sign2_d    = b_sign_eff;
          frac1_d    = a_frac0;
          frac2_d    = b_frac0;
          frm_d      = frm;
          spec_d     = in_spec;
          spec_res_d = in_res;
          inv_d      = in_inv;
          shift_b_d  = b_smaller;
          rem_d      = d_cap;
          if (in_spec || (d_cap == 5'd0)) begin
            rem_d   = 5'd0;
            state_d = S_HOLD;
          end else begin
            state_d = S_ALIGN;
          end
        end
      end
      S_ALIGN: begin
        if (shift_b_q) begin
          frac2_d = shift_res;
        end else begin
          frac1_d = shift_res;
        end
        rem_d = rem_q - step_k;
        if (rem_q <= step_k) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; async reset discards any operation in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= S_IDLE;
      rem_q      <= 5'd0;
      shift_b_q  <= 1'b0;
      exp_max_q  <= 8'd0;
      sign1_q    <= 1'b0;
      sign2_q    <= 1'b0;
      frac1_q    <= 26'd0;
      frac2_q    <= 26'd0;
      frm_q      <= 3'd0;
      spec_q     <= 1'b0;
      spec_res_q <= 32'd0;
      inv_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      shift_b_q  <= shift_b_d;
      exp_max_q  <= exp_max_d;
      sign1_q    <= sign1_d;
      sign2_q    <= sign2_d;
      frac1_q    <= frac1_d;
      frac2_q    <= frac2_d;
      frm_q      <= frm_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      inv_q      <= inv_d;
    end
  end

  assign in_ready         = (state_q == S_IDLE);
  assign out_valid        = (state_q == S_HOLD);
  assign exponent_max_out = exp_max_q;
  assign sign1_out        = sign1_q;
  assign sign2_out        = sign2_q;
  assign frac1_out        = frac1_q;
  assign frac2_out        = frac2_q;
  assign frm_out          = frm_q;
  assign special_valid    = spec_q;
  assign special_result   = spec_res_q;
  assign inv_out          = inv_q;

endmodule

// File: tb/tb_fp_add_unpack_align.sv
// Directed bench for fp_add_unpack_align with SHIFT_PER_CYCLE = 4.
module tb_fp_add_unpack_align;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] floating_point1;
  logic [31:0] floating_point2;
  logic        is_sub;
  logic [2:0]  frm;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exponent_max_out;
  logic        sign1_out;
  logic        sign2_out;
  logic [25:0] frac1_out;
  logic [25:0] frac2_out;
  logic [2:0]  frm_out;
  logic        special_valid;
  logic [31:0] special_result;
  logic        inv_out;

  int n_checks = 0;
  int n_fail   = 0;

  fp_add_unpack_align #(.SHIFT_PER_CYCLE(4)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
    .floating_point1(floating_point1), .floating_point2(floating_point2),
    .is_sub(is_sub), .frm(frm), .out_valid(out_valid), .out_ready(out_ready),
    .exponent_max_out(exponent_max_out), .sign1_out(sign1_out),
    .sign2_out(sign2_out), .frac1_out(frac1_out), .frac2_out(frac2_out),
    .frm_out(frm_out), .special_valid(special_valid),
    .special_result(special_result), .inv_out(inv_out)
  );

  always #5 CLK = ~CLK;

  // Present one operation, then count edges from the accept edge until out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [2:0] rm, output int lat);
    @(negedge CLK);
    floating_point1 = a;
    floating_point2 = b;
    is_sub          = sub;
    frm             = rm;
    in_valid        = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic release_op();
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_checks++; if ({exponent_max_out, frac1_out, frac2_out, special_result, special_valid, inv_out} !== '0)
      begin n_fail++; $display("FAIL rst_outputs got %h/%h/%h/%h want all zero", exponent_max_out, frac1_out, frac2_out, special_result); end
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  task automatic test_align_small();
    int lat;
    run_op(32'h4000_0000, 32'h3F80_0000, 1'b0, 3'b101, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL add21_lat got %0d want 2", lat); end
    n_checks++; if (exponent_max_out !== 8'h80) begin n_fail++; $display("FAIL add21_exp got %h want 80", exponent_max_out); end
    n_checks++; if (frac1_out !== 26'h2000000) begin n_fail++; $display("FAIL add21_frac1 got %h want 2000000", frac1_out); end
    n_checks++; if (frac2_out !== 26'h1000000) begin n_fail++; $display("FAIL add21_frac2 got %h want 1000000", frac2_out); end
    n_checks++; if (frm_out !== 3'b101) begin n_fail++; $display("FAIL add21_frm got %b want 101", frm_out); end
    n_checks++; if (special_valid !== 1'b0) begin n_fail++; $display("FAIL add21_spec got %b want 0", special_valid); end
    release_op();
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL add21_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
    // Larger exponent on B: A is the operand that moves.
    run_op(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'b000, lat);
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL add12_lat got %0d want 2", lat); end
    n_checks++; if (frac1_out !== 26'h1000000 || frac2_out !== 26'h2000000)
      begin n_fail++; $display("FAIL add12_frac got %h/%h want 1000000/2000000", frac1_out, frac2_out); end
    release_op();
  endtask

  task automatic test_equal_sub();
    int lat;
    run_op(32'h3F80_0000, 32'h3F80_0000, 1'b1, 3'b010, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL sub11_lat got %0d want 1", lat); end
    n_checks++; if (sign1_out !== 1'b0 || sign2_out !== 1'b1)
      begin n_fail++; $display("FAIL sub11_signs got %b/%b want 0/1", sign1_out, sign2_out); end
    n_checks++; if (frac1_out !== 26'h2000000 || frac2_out !== 26'h2000000)
      begin n_fail++; $display("FAIL sub11_frac got %h/%h want 2000000/2000000", frac1_out, frac2_out); end
    n_checks++; if (exponent_max_out !== 8'h7F) begin n_fail++; $display("FAIL sub11_exp got %h want 7f", exponent_max_out); end
    n_checks++; if (special_valid !== 1'b0) begin n_fail++; $display("FAIL sub11_spec got %b want 0", special_valid); end
    release_op();
    // Subnormal A against smallest normal B: both effective exponents are 1.
    run_op(32'h0000_0001, 32'h0080_0000, 1'b0, 3'b000, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL subn_lat got %0d want 1", lat); end
    n_checks++; if (exponent_max_out !== 8'h01 || frac1_out !== 26'h0000004 || frac2_out !== 26'h2000000)
      begin n_fail++; $display("FAIL subn_vals got %h/%h/%h want 01/0000004/2000000", exponent_max_out, frac1_out, frac2_out); end
    release_op();
  endtask

  task automatic test_large_diff();
    int lat;
    run_op(32'h4B80_0000, 32'h3F80_0000, 1'b0, 3'b000, lat);
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL d24_lat got %0d want 7", lat); end
    n_checks++; if (frac2_out !== 26'h0000002) begin n_fail++; $display("FAIL d24_frac2 got %h want 0000002", frac2_out); end
    n_checks++; if (frac1_out !== 26'h2000000 || exponent_max_out !== 8'h97)
      begin n_fail++; $display("FAIL d24_a got %h/%h want 2000000/97", frac1_out, exponent_max_out); end
    release_op();
    run_op(32'h4E80_0000, 32'h3F80_0000, 1'b0, 3'b000, lat);
    n_checks++; if (lat !== 8) begin n_fail++; $display("FAIL d30_lat got %0d want 8", lat); end
    n_checks++; if (frac2_out !== 26'h0000001) begin n_fail++; $display("FAIL d30_frac2 got %h want 0000001", frac2_out); end
    n_checks++; if (exponent_max_out !== 8'h9D) begin n_fail++; $display("FAIL d30_exp got %h want 9d", exponent_max_out); end
    release_op();
  endtask

  task automatic test_inf();
    int lat;
    run_op(32'h7F80_0000, 32'hFF80_0000, 1'b0, 3'b000, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL infconf_lat got %0d want 1", lat); end
    n_checks++; if (special_valid !== 1'b1 || inv_out !== 1'b1 || special_result !== 32'h7FC00000)
      begin n_fail++; $display("FAIL infconf got sv=%b inv=%b res=%h want 1/1/7fc00000", special_valid, inv_out, special_result); end
    release_op();
    run_op(32'h7F80_0000, 32'h7F80_0000, 1'b1, 3'b000, lat);
    n_checks++; if (inv_out !== 1'b1 || special_result !== 32'h7FC00000)
      begin n_fail++; $display("FAIL infsub got inv=%b res=%h want 1/7fc00000", inv_out, special_result); end
    release_op();
    run_op(32'h3F80_0000, 32'h7F80_0000, 1'b1, 3'b000, lat);
    n_checks++; if (special_valid !== 1'b1 || inv_out !== 1'b0 || special_result !== 32'hFF800000)
      begin n_fail++; $display("FAIL infb got sv=%b inv=%b res=%h want 1/0/ff800000", special_valid, inv_out, special_result); end
    release_op();
    run_op(32'h7F80_0000, 32'h3F80_0000, 1'b0, 3'b000, lat);
    n_checks++; if (lat !== 1 || inv_out !== 1'b0 || special_result !== 32'h7F800000)
      begin n_fail++; $display("FAIL infa got lat=%0d inv=%b res=%h want 1/0/7f800000", lat, inv_out, special_result); end
    release_op();
  endtask

  task automatic test_nan();
    int lat;
    run_op(32'h7FA0_0000, 32'h3F80_0000, 1'b0, 3'b000, lat);
    n_checks++; if (lat !== 1 || special_valid !== 1'b1 || inv_out !== 1'b1 || special_result !== 32'h7FC00000)
      begin n_fail++; $display("FAIL snan got lat=%0d sv=%b inv=%b res=%h want 1/1/1/7fc00000", lat, special_valid, inv_out, special_result); end
    release_op();
    run_op(32'h7FC0_0000, 32'h3F80_0000, 1'b0, 3'b000, lat);
    n_checks++; if (special_valid !== 1'b1 || inv_out !== 1'b0 || special_result !== 32'h7FC00000)
      begin n_fail++; $display("FAIL qnan got sv=%b inv=%b res=%h want 1/0/7fc00000", special_valid, inv_out, special_result); end
    release_op();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(32'h4000_0000, 32'h3F80_0000, 1'b0, 3'b000, lat);
    // A new operation offered during HOLD must be ignored.
    @(negedge CLK);
    floating_point1 = 32'h4B80_0000;
    in_valid        = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK);
      #1;
      n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || frac2_out !== 26'h1000000 || exponent_max_out !== 8'h80)
        begin n_fail++; $display("FAIL hold_c%0d got ov=%b ir=%b f2=%h e=%h want 1/0/1000000/80", c, out_valid, in_ready, frac2_out, exponent_max_out); end
    end
    // Release with in_valid still high: the release edge must not also accept.
    @(negedge CLK);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin n_fail++; $display("FAIL b2b_noaccept got ov=%b ir=%b want 0/1", out_valid, in_ready); end
    // The next edge accepts the pending 4B800000 + 3F800000 (latency 7).
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    n_checks++; if (lat !== 7 || frac2_out !== 26'h0000002)
      begin n_fail++; $display("FAIL b2b_next got lat=%0d f2=%h want 7/0000002", lat, frac2_out); end
    release_op();
  endtask

  task automatic test_reset_mid_align();
    int lat;
    @(negedge CLK);
    floating_point1 = 32'h4B80_0000;
    floating_point2 = 32'h3F80_0000;
    is_sub          = 1'b0;
    in_valid        = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    @(posedge CLK);
    #1;
    n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
      begin n_fail++; $display("FAIL align_busy got ir=%b ov=%b want 0/0", in_ready, out_valid); end
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || frac2_out !== 26'd0)
      begin n_fail++; $display("FAIL midrst got ov=%b ir=%b f2=%h want 0/1/0000000", out_valid, in_ready, frac2_out); end
    @(negedge CLK);
    nRST = 1'b1;
    run_op(32'h4000_0000, 32'h3F80_0000, 1'b0, 3'b000, lat);
    n_checks++; if (lat !== 2 || frac2_out !== 26'h1000000)
      begin n_fail++; $display("FAIL after_rst got lat=%0d f2=%h want 2/1000000", lat, frac2_out); end
    release_op();
  endtask

  initial begin
    in_valid        = 1'b0;
    out_ready       = 1'b0;
    floating_point1 = 32'd0;
    floating_point2 = 32'd0;
    is_sub          = 1'b0;
    frm             = 3'd0;
    test_reset();
    test_align_small();
    test_equal_sub();
    test_large_diff();
    test_inf();
    test_nan();
    test_backpressure();
    test_reset_mid_align();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
